// File: rtl/hamming_12_8_pkg.sv
// hamming_12_8_pkg: Hamming(12,8) constants, error classes and codeword helpers shared with the encoder
package hamming_12_8_pkg;
  localparam int CW_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W = 4;
  localparam int P_POS [4] = '{1, 2, 4, 8};
  localparam int D_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};
  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_MULTI} err_t;
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int i = 0; i < CW_W; i++) s ^= cw[i] ? SYN_W'(i + 1) : '0;
    return s;
  endfunction
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W; k++) d[k] = cw[D_POS[k] - 1];
    return d;
  endfunction
endpackage

// File: rtl/hamming_12_8_dec_pipe_if.sv
// hamming_12_8_dec_pipe_if: codeword input stream and decoded output stream of the decoder
interface hamming_12_8_dec_pipe_if;
  import hamming_12_8_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [CW_W-1:0] in_codeword;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_corrected;
  logic out_uncorrectable;
  logic [SYN_W-1:0] out_syndrome;
  modport master (
    output in_valid, in_codeword, out_ready,
    input in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
  );
  modport slave (
    input in_valid, in_codeword, out_ready,
    output in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
  );
endinterface

// File: rtl/hamming_12_8_syndrome.sv
// hamming_12_8_syndrome: combinational syndrome and none/single/uncorrectable classification
module hamming_12_8_syndrome
  import hamming_12_8_pkg::*;
(
  input logic [CW_W-1:0] cw,
  output logic [SYN_W-1:0] syn,
  output err_t cls
);
  always_comb begin
    syn = calc_syndrome(cw);
    cls = syn == '0 ? ERR_NONE : syn > SYN_W'(CW_W) ? ERR_MULTI : ERR_SINGLE;
  end
endmodule

// File: rtl/hamming_12_8_dec_pipe.sv
// hamming_12_8_dec_pipe: 2-stage streaming Hamming(12,8) SEC decoder; HAMMING_DEC_ERR_STATS_EN adds error counters
module hamming_12_8_dec_pipe
  import hamming_12_8_pkg::*;
`ifdef HAMMING_DEC_ERR_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input logic clk,
  input logic rst,
  hamming_12_8_dec_pipe_if.slave bus
`ifdef HAMMING_DEC_ERR_STATS_EN
  ,
  input logic stats_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
`endif
);
  logic s1_valid, s1_ready, s2_ready;
  logic [CW_W-1:0] s1_cw, cw_fix;
  logic [SYN_W-1:0] s1_syn, syn;
  err_t s1_cls, cls;
  logic out_valid, out_corrected, out_uncorrectable;
  logic [DATA_W-1:0] out_data;
  logic [SYN_W-1:0] out_syndrome;
  hamming_12_8_syndrome u_syn (.cw(bus.in_codeword), .syn(syn), .cls(cls));
  always_comb begin
    s2_ready = !out_valid || bus.out_ready;
    s1_ready = !s1_valid || s2_ready;
    cw_fix = s1_cls == ERR_SINGLE ? s1_cw ^ (CW_W'(1) << (s1_syn - 1'b1)) : s1_cw;
  end
  assign bus.in_ready = s1_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_corrected = out_corrected;
  assign bus.out_uncorrectable = out_uncorrectable;
  assign bus.out_syndrome = out_syndrome;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw <= '0;
      s1_syn <= '0;
      s1_cls <= ERR_NONE;
    end else begin
      if (s1_ready) s1_valid <= bus.in_valid;
      if (bus.in_valid && s1_ready) begin
        s1_cw <= bus.in_codeword;
        s1_syn <= syn;
        s1_cls <= cls;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_corrected <= 1'b0;
      out_uncorrectable <= 1'b0;
      out_syndrome <= '0;
    end else begin
      if (s2_ready) out_valid <= s1_valid;
      if (s1_valid && s2_ready) begin
        out_data <= extract_data(cw_fix);
        out_corrected <= s1_cls == ERR_SINGLE;
        out_uncorrectable <= s1_cls == ERR_MULTI;
        out_syndrome <= s1_syn;
      end
    end
`ifdef HAMMING_DEC_ERR_STATS_EN
  logic out_fire;
  assign out_fire = out_valid && bus.out_ready;
  // clear wins over a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk or posedge rst)
    if (rst || stats_clr) begin
      corr_cnt <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (out_fire && out_corrected && !(&corr_cnt)) corr_cnt <= corr_cnt + 1'b1;
      if (out_fire && out_uncorrectable && !(&uncorr_cnt)) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
`endif
endmodule

// File: doc/hamming_12_8_dec_pipe.md
Name: hamming_12_8_dec_pipe

Overview:
- Streaming Hamming(12,8) single-error-correcting decoder.
- Sits directly downstream of the 8-to-12-bit codeword encoder stage.
- Accepts 12-bit codewords over a valid/ready handshake and emits corrected 8-bit data plus error status.
- Two-stage pipeline: syndrome, then correct/extract. Full throughput; backpressure-safe.

Parameters:
- CNT_W, 16, width of the saturating error-statistics counters (used only with the optional feature).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  codeword present.
- in_ready  output  1  decoder can accept this cycle.
- in_codeword  input  12  codeword; bit i = Hamming position i+1.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- out_data  output  8  corrected data.
- out_corrected  output  1  single-bit error was corrected.
- out_uncorrectable  output  1  syndrome 13..15; data passed uncorrected.
- out_syndrome  output  4  raw syndrome, for debug.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Codeword layout:
  - Parity bits at positions 1, 2, 4, 8.
  - Data d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Even parity; p_k covers every position whose index has bit k set.
- Stage 1 (S1): on an in_valid && in_ready transfer, register the codeword and the 4-bit syndrome (XOR of indices of all set positions). Set s1_valid.
- Stage 2 (S2, output register), on an S1 transfer into S2:
  - Syndrome 0: data = extracted bits; corrected=0; uncorrectable=0.
  - Syndrome 1..12: flip position s, then extract; corrected=1. A flipped parity position (1, 2, 4, 8) still sets corrected=1, with data unchanged.
  - Syndrome 13..15: extract without flipping; uncorrectable=1; corrected=0.
- Handshake:
  - s2_ready = !out_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready (combinational chain, no skid buffer).
  - in_ready may not depend on in_valid.
- Latency: accepted codeword appears on out_* 2 cycles later when out_ready stays high. Sustains 1 word/cycle.
- Stall: while out_valid && !out_ready, out_* stay stable. S1 holds if full. in_ready deasserts once both stages are full.
- Simultaneous cases:
  - A transfer out and a transfer in during the same cycle in a full pipeline both complete; no bubble.
  - S1 empty while S2 drains: out_valid drops the next cycle.
- Reset (any time, including mid-transfer):
  - out_valid=0, s1_valid=0, in_ready=1 after reset release.
  - out_data=0, out_corrected=0, out_uncorrectable=0, out_syndrome=0.
  - In-flight words are discarded.
- Known limitation: double errors with syndrome ≤12 are miscorrected silently. This is SEC only, not SECDED.

Optional Feature:
- Macro: HAMMING_DEC_ERR_STATS_EN.
- With macro:
  - Adds input stats_clr (1).
  - Adds outputs corr_cnt (CNT_W) and uncorr_cnt (CNT_W).
  - Counters increment once per out_valid && out_ready transfer carrying the respective flag.
  - Counters saturate at all-ones.
  - stats_clr zeroes both the next cycle and wins over a simultaneous increment.
  - rst zeroes both.
- Without macro: the extra ports and counters are absent; other behaviour is identical.

Decomposition:
- Package hamming_12_8_pkg:
  - Constants CW_W=12, DATA_W=8, SYN_W=4.
  - Position-index constants for the parity and data positions.
  - Functions calc_syndrome(cw) and extract_data(cw), shared with the encoder.
- One natural sub-module: hamming_12_8_syndrome (combinational syndrome + classify), instantiated in S1.

Test Plan:
- Clean words 12'h007 then 12'hA58, out_ready=1 → out_data=8'h01 then 8'hAA, 2 cycles after acceptance. corrected=0, uncorrectable=0, syndrome=0.
- 12'hA48 (position 5 flipped) → out_data=8'hAA, out_corrected=1, out_syndrome=4'd5.
- 12'h006 (parity position 1 flipped) → out_data=8'h01, corrected=1, syndrome=1.
- 12'h806 (positions 1 and 12 flipped) → out_uncorrectable=1, out_syndrome=4'd13, corrected=0.
- Backpressure:
  - Stream 20 random clean words with out_ready toggling pseudo-randomly.
  - Required: all 20 outputs in order, no loss or duplication, out_* stable while stalled, in_ready=0 only with both stages full.
  - Assert rst mid-stream: out_valid=0 immediately (asynchronous), outputs zero, first post-reset word decodes correctly.
- With HAMMING_DEC_ERR_STATS_EN:
  - Send 3 corrected and 1 uncorrectable word → corr_cnt=3, uncorr_cnt=1.
  - Pulse stats_clr → both 0.
  - With CNT_W=2, send 5 corrected words → corr_cnt=3 (saturated).
